ofm_writeback: RTL

OFM_WRITEBACK -- requirements
Module: ofm_writeback

---
 rtl/dpu_pkg.sv | 13 +
 rtl/vec_fifo.sv | 56 +++++
 rtl/ofm_writeback.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/dpu_pkg.sv
// rtl/dpu_pkg.sv - shared writeback FSM states and word-packing constants
package dpu_pkg;

    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINISH = 2'd2
    } wb_state_e;

endpackage

// File: rtl/vec_fifo.sv
// rtl/vec_fifo.sv - vector FIFO; a push while full is taken only alongside a pop
module vec_fifo #(
    parameter int WIDTH = 256,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];

    // Storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/ofm_writeback.sv
// rtl/ofm_writeback.sv - output feature-map writeback: buffers int8 vectors and streams them as 32-bit words
// Optional running checksum of written words when OFM_CHECKSUM_EN is defined.
module ofm_writeback
    import dpu_pkg::*;
#(
    parameter int LANES  = 32,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [15:0]         num_vectors,
    input  logic                in_valid,
    input  logic [LANES*8-1:0]  in_data,
    output logic                mem_req,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    input  logic                mem_ready,
    output logic                busy,
    output logic                finished,
    output logic                overflow,
    output logic [31:0]         checksum
);

    localparam int WPV = LANES / BYTES_PER_WORD;
    localparam int WIW = (WPV > 1) ? $clog2(WPV) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    wb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       vec_cnt_q, vec_cnt_d;
    logic [ADDR_W-1:0] word_cnt_q, word_cnt_d;
    logic [WIW-1:0]    word_idx_q, word_idx_d;
    logic              overflow_q, overflow_d;

    logic                fifo_push, fifo_pop, fifo_full, fifo_empty, fifo_flush;
    logic [LANES*8-1:0]  fifo_dout;
    logic [CW-1:0]       fifo_count;
    logic                accept_in, drop, head_valid, last_word, mem_fire, job_start;
    logic [WORD_W-1:0]   head_word;

    vec_fifo #(
        .WIDTH (LANES*8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (fifo_flush),
        .push  (fifo_push),
        .din   (in_data),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign job_start  = (state_q == ST_IDLE) && start;
    assign accept_in  = in_valid && (state_q == ST_ACTIVE);
    assign head_valid = (fifo_count != '0);
    assign last_word  = (word_idx_q == WIW'(WPV-1));
    assign head_word  = fifo_dout[WORD_W*word_idx_q +: WORD_W];

    assign mem_req   = (state_q == ST_ACTIVE) && (vec_cnt_q != num_q) && head_valid;
    assign mem_fire  = mem_req && mem_ready;
    assign mem_addr  = mem_req ? (base_q + word_cnt_q) : '0;
    assign mem_wdata = mem_req ? head_word : '0;

    assign fifo_pop   = mem_fire && last_word && !fifo_empty;
    assign fifo_push  = accept_in && (!fifo_full || fifo_pop);
    assign drop       = accept_in && fifo_full && !fifo_pop;
    // Anything still queued past the requested vector count is thrown away here.
    assign fifo_flush = (state_q == ST_FINISH);

    assign busy     = (state_q != ST_IDLE);
    assign finished = (state_q == ST_FINISH);
    assign overflow = overflow_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        num_d      = num_q;
        vec_cnt_d  = vec_cnt_q;
        word_cnt_d = word_cnt_q;
        word_idx_d = word_idx_q;
        overflow_d = overflow_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_ACTIVE;
                    base_d     = base_addr;
                    num_d      = num_vectors;
                    vec_cnt_d  = '0;
                    word_cnt_d = '0;
                    word_idx_d = '0;
                    overflow_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (drop) overflow_d = 1'b1;
                if (mem_fire) begin
                    word_cnt_d = word_cnt_q + ADDR_W'(1);
                    if (last_word) begin
                        word_idx_d = '0;
                        vec_cnt_d  = vec_cnt_q + 16'd1;
                    end else begin
                        word_idx_d = word_idx_q + WIW'(1);
                    end
                end
                // Compare against the post-handshake count so finished follows the last write directly.
                if (vec_cnt_d == num_q) state_d = ST_FINISH;
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            base_q     <= '0;
            num_q      <= '0;
            vec_cnt_q  <= '0;
            word_cnt_q <= '0;
            word_idx_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            num_q      <= num_d;
            vec_cnt_q  <= vec_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_idx_q <= word_idx_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef OFM_CHECKSUM_EN
    logic [31:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (job_start) begin
            csum_q <= '0;
        end else if (mem_fire) begin
            csum_q <= csum_q + mem_wdata;
        end
    end

    assign checksum = csum_q;
`else
    logic unused_job_start;
    assign unused_job_start = job_start;
    assign checksum         = '0;
`endif

endmodule
